cic_decimator_iq: RTL and testbench
===================================

Name: cic_decimator_iq

Overview:
- Dual-channel (I/Q) CIC decimating filter that sits directly downstream of the NCO/CORDIC mixer.
- Consumes the 22-bit I/Q baseband samples the mixer produces every clock.
- Decimates by a fixed integer rate and emits rounded, strobed output samples for the next filter stage (CFIR/FIR).
- One shared sample counter serves both channels; each channel has its own integrator and comb chains.

Parameters:
- IN_WIDTH, 22, input sample width; matches mixer output width.
- STAGES, 5, number of integrator and comb stages (N); comb differential delay M = 1.
- DECIMATION, 40, decimation ratio R; legal range 2..1024.
- ACC_WIDTH, 49, accumulator width; must equal IN_WIDTH + ceil(STAGES*log2(DECIMATION)).
- OUT_WIDTH, 24, output sample width; legal range 2..ACC_WIDTH-1.

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, asynchronous, active-high; clears all state.
- in_strobe, input, 1, input sample valid; may be held high every cycle.
- in_data_I, input, IN_WIDTH, signed I sample.
- in_data_Q, input, IN_WIDTH, signed Q sample.
- out_strobe, output, 1, one-cycle pulse marking a valid output pair.
- out_data_I, output, OUT_WIDTH, signed decimated I sample.
- out_data_Q, output, OUT_WIDTH, signed decimated Q sample.

Behaviour:
- Reset (async assert, deassert synchronised externally):
  - integrators, comb registers, comb delay registers, sample counter, valid pipeline all cleared to 0.
  - out_strobe = 0, out_data_I = out_data_Q = 0.
  - Reset mid-decimation discards the partial sample; the first output after reset requires DECIMATION fresh strobes.
- Input:
  - sign-extended to ACC_WIDTH.
  - Integrators advance only on cycles with in_strobe = 1; otherwise they hold.
  - Integrator k (1..STAGES) is registered: int[k] <= int[k] + int[k-1], where int[0] is the extended input.
- Arithmetic:
  - All accumulation is modular two's complement in ACC_WIDTH bits.
  - Integrator overflow wraps and must not saturate; the combs recover the correct result.
- Counter:
  - 0..DECIMATION-1, incremented on each in_strobe.
  - On the in_strobe where count == DECIMATION-1, count returns to 0 and a decimation tick fires.
  - The tick captures int[STAGES] as registered in that same cycle.
- Combs:
  - STAGES-deep pipeline, one register per stage, advanced by a valid bit shifted every clock.
  - c[k] = c[k-1] - d[k]; d[k] <= c[k-1], updated only when that stage's valid is set.
- Rounding:
  - Output = bits [ACC_WIDTH-1 : ACC_WIDTH-OUT_WIDTH] of the last comb, convergent-rounded (round half to even) on the discarded bits.
  - Rounding carry is absorbed in the ACC_WIDTH-bit sum before truncation; no saturation, since the gain design guarantees headroom.
- Latency: out_strobe pulses exactly STAGES+2 clocks after the in_strobe cycle that produced the tick (capture + STAGES combs + round/output register).
- Output hold: out_data_I/Q hold their value until the next out_strobe.
- Throughput: in_strobe continuously high yields exactly one out_strobe per DECIMATION clocks. Output valid pipeline entries never collide, since DECIMATION >= 2.
- Channel alignment: I and Q share the counter, valid pipeline and rounding timing; they are always output in the same cycle.
- DC gain: DECIMATION^STAGES / 2^(ACC_WIDTH-OUT_WIDTH). For defaults this is 1.024e8/2^25 = 3.0517578125.
- in_strobe low between samples: no state advances except the comb/valid pipeline, which always drains.

Test Plan:
- Reset check: assert reset asynchronously mid-run with count = 17 and nonzero integrators -> all outputs 0 immediately. After release, the first out_strobe arrives only after 40 new strobes + 7 clocks.
- DC settle: in_strobe = 1, I = +1000, Q = -1000 constant -> from the 6th output onward, out_data_I = 3052, out_data_Q = -3052. out_strobe period is exactly 40 clocks, and each pulse is 7 clocks after the wrapping strobe.
- Full scale: I = 2097151, Q = -2097152 -> settled I = 6399997, Q = -6400000; no overflow of OUT_WIDTH.
- Wrap-around: full-scale DC for 2,000,000 clocks (integrators wrap many times) -> outputs remain exactly 6399997 / -6400000 throughout.
- Gapped strobes: in_strobe high one cycle in three with DC 1000 -> identical output values to the DC settle test; out_strobe period is 120 clocks.
- Impulse: single I = 1 at count 0, then zeros, with DECIMATION = 4, STAGES = 2, ACC_WIDTH = 26, OUT_WIDTH = 24 -> raw comb outputs match the CIC impulse response [1, 2, 1 ... ]·R-tap sums, cross-checked against a bit-exact model for the first 4 outputs. Q stays 0.

Source files
------------

// File: rtl/cic_decimator_iq.sv
// Dual-channel (I/Q) CIC decimator: STAGES integrators at the input rate, STAGES combs
// at the decimated rate, then convergent rounding down to OUT_WIDTH bits.
module cic_decimator_iq #(
  parameter int IN_WIDTH   = 22,
  parameter int STAGES     = 5,
  parameter int DECIMATION = 40,
  parameter int ACC_WIDTH  = 49,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data_I,
  input  logic signed [IN_WIDTH-1:0]  in_data_Q,
  output logic                        out_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data_I,
  output logic signed [OUT_WIDTH-1:0] out_data_Q
);

  localparam int CNT_WIDTH = $clog2(DECIMATION);
  localparam int DROP      = ACC_WIDTH - OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DECIMATION - 1);
  // Adding (half - 1) plus the kept LSB rounds ties toward the even result.
  localparam logic [ACC_WIDTH-1:0] HALF_M1 = (ACC_WIDTH'(1) << (DROP - 1)) - ACC_WIDTH'(1);

  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic                      tick_q, tick_d;
  logic [STAGES:0]           valid_q, valid_d;
  logic                      out_strobe_q, out_strobe_d;
  logic [1:0][IN_WIDTH-1:0]  din;

  assign din = {in_data_Q, in_data_I};

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (in_strobe) begin
      if (count_q == CNT_LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end
  end

  // valid_q[0] marks a fresh capture, valid_q[k] a fresh comb stage k output.
  always_comb begin
    valid_d      = {valid_q[STAGES-1:0], tick_q};
    out_strobe_d = valid_q[STAGES];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      tick_q       <= 1'b0;
      valid_q      <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      tick_q       <= tick_d;
      valid_q      <= valid_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  assign out_strobe = out_strobe_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [ACC_WIDTH-1:0] ext;
      logic [ACC_WIDTH-1:0] integ_q [STAGES];
      logic [ACC_WIDTH-1:0] integ_d [STAGES];
      logic [ACC_WIDTH-1:0] comb_q  [STAGES+1];
      logic [ACC_WIDTH-1:0] comb_d  [STAGES+1];
      logic [ACC_WIDTH-1:0] dly_q   [STAGES];
      logic [ACC_WIDTH-1:0] dly_d   [STAGES];
      logic [ACC_WIDTH-1:0] rnd;
      logic [OUT_WIDTH-1:0] dout_q, dout_d;

      assign ext = {{(ACC_WIDTH-IN_WIDTH){din[gi][IN_WIDTH-1]}}, din[gi]};

      always_comb begin
        // Integrators wrap modulo 2^ACC_WIDTH; the combs undo the wrap exactly.
        integ_d[0] = in_strobe ? integ_q[0] + ext : integ_q[0];
        for (int k = 1; k < STAGES; k++) begin
          integ_d[k] = in_strobe ? integ_q[k] + integ_q[k-1] : integ_q[k];
        end

        comb_d[0] = tick_q ? integ_q[STAGES-1] : comb_q[0];
        for (int k = 1; k <= STAGES; k++) begin
          comb_d[k]  = comb_q[k];
          dly_d[k-1] = dly_q[k-1];
          if (valid_q[k-1]) begin
            comb_d[k]  = comb_q[k-1] - dly_q[k-1];
            dly_d[k-1] = comb_q[k-1];
          end
        end

        rnd    = comb_q[STAGES] + HALF_M1 + ACC_WIDTH'(comb_q[STAGES][DROP]);
        dout_d = valid_q[STAGES] ? rnd[ACC_WIDTH-1:DROP] : dout_q;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < STAGES; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
          end
          for (int k = 0; k <= STAGES; k++) begin
            comb_q[k] <= '0;
          end
          dout_q <= '0;
        end else begin
          integ_q <= integ_d;
          dly_q   <= dly_d;
          comb_q  <= comb_d;
          dout_q  <= dout_d;
        end
      end
    end
  endgenerate

  assign out_data_I = g_ch[0].dout_q;
  assign out_data_Q = g_ch[1].dout_q;

endmodule

// File: tb/tb_cic_decimator_iq.sv
// Bench for cic_decimator_iq: default configuration plus a small R=4/N=2 instance, both
// checked against a direct-form FIR model of the CIC response (boxcar^N) with convergent rounding.
module tb_cic_decimator_iq;

  localparam int IN_W  = 22;
  localparam int R_A   = 40;
  localparam int N_A   = 5;
  localparam int ACC_A = 49;
  localparam int OUT_A = 24;
  localparam int R_B   = 4;
  localparam int N_B   = 2;
  localparam int ACC_B = 26;
  localparam int OUT_B = 24;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stb_a = 1'b0;
  logic stb_b = 1'b0;
  logic signed [IN_W-1:0]  i_a = '0, q_a = '0, i_b = '0, q_b = '0;
  logic                    os_a, os_b;
  logic signed [OUT_A-1:0] oi_a, oq_a;
  logic signed [OUT_B-1:0] oi_b, oq_b;

  always #5 clock = ~clock;

  cic_decimator_iq u_dut_a (
    .clock(clock), .reset(reset), .in_strobe(stb_a),
    .in_data_I(i_a), .in_data_Q(q_a),
    .out_strobe(os_a), .out_data_I(oi_a), .out_data_Q(oq_a)
  );

  cic_decimator_iq #(
    .IN_WIDTH(IN_W), .STAGES(N_B), .DECIMATION(R_B), .ACC_WIDTH(ACC_B), .OUT_WIDTH(OUT_B)
  ) u_dut_b (
    .clock(clock), .reset(reset), .in_strobe(stb_b),
    .in_data_I(i_b), .in_data_Q(q_b),
    .out_strobe(os_b), .out_data_I(oi_b), .out_data_Q(oq_b)
  );

  typedef struct {
    int     cyc;
    longint vi;
    longint vq;
  } exp_t;

  exp_t   exp_a[$], exp_b[$];
  longint hist_ia[$], hist_qa[$], hist_ib[$], hist_qb[$];
  longint h_a[$], h_b[$];
  longint outs_ib[$], outs_qb[$];
  longint last_i[2], last_q[2], seen_i[2], seen_q[2];
  int     last_cyc[2], prev_cyc[2];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  task automatic check_val(input string tag, input longint got, input longint want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Impulse response of N cascaded R-tap boxcars.
  task automatic build_h(input int d);
    longint cur[$];
    longint nxt[$];
    int r, n;
    r = (d == 0) ? R_A : R_B;
    n = (d == 0) ? N_A : N_B;
    cur.push_back(1);
    repeat (n) begin
      nxt.delete();
      for (int j = 0; j < cur.size() + r - 1; j++) begin
        longint s;
        s = 0;
        for (int t = 0; t < r; t++)
          if (j - t >= 0 && j - t < cur.size()) s += cur[j-t];
        nxt.push_back(s);
      end
      cur = nxt;
    end
    if (d == 0) h_a = cur; else h_b = cur;
  endtask

  // Full-precision filter output at the latest decimation point; samples before reset are zero.
  function automatic longint raw_sum(input int d, input int ch);
    longint acc, x, h;
    int base, taps, idx;
    acc  = 0;
    base = (d == 0) ? hist_ia.size() - N_A : hist_ib.size() - N_B;
    taps = (d == 0) ? h_a.size() : h_b.size();
    for (int i = 0; i < taps; i++) begin
      idx = base - i;
      if (idx >= 0) begin
        if (d == 0) begin
          x = (ch == 0) ? hist_ia[idx] : hist_qa[idx];
          h = h_a[i];
        end else begin
          x = (ch == 0) ? hist_ib[idx] : hist_qb[idx];
          h = h_b[i];
        end
        acc += x * h;
      end
    end
    return acc;
  endfunction

  function automatic longint round_conv(input longint v, input int drop, input int ow);
    longint q, r, half;
    q    = v >>> drop;
    r    = v - (q <<< drop);
    half = longint'(1) <<< (drop - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    q = (q <<< (64 - ow)) >>> (64 - ow);
    return q;
  endfunction

  function automatic longint rnd_s();
    longint v;
    v = longint'($urandom_range(0, (1 << IN_W) - 1));
    if (v >= (1 << (IN_W - 1))) v -= (1 << IN_W);
    return v;
  endfunction

  task automatic drive(input logic sa, input longint ia, input longint qa,
                       input logic sb, input longint ib, input longint qb);
    exp_t e;
    stb_a = sa; i_a = ia[IN_W-1:0]; q_a = qa[IN_W-1:0];
    stb_b = sb; i_b = ib[IN_W-1:0]; q_b = qb[IN_W-1:0];
    @(posedge clock);
    cyc++;
    if (!reset && sa) begin
      hist_ia.push_back(ia);
      hist_qa.push_back(qa);
      if (hist_ia.size() % R_A == 0) begin
        e.cyc = cyc + N_A + 2;
        e.vi  = round_conv(raw_sum(0, 0), ACC_A - OUT_A, OUT_A);
        e.vq  = round_conv(raw_sum(0, 1), ACC_A - OUT_A, OUT_A);
        exp_a.push_back(e);
      end
    end
    if (!reset && sb) begin
      hist_ib.push_back(ib);
      hist_qb.push_back(qb);
      if (hist_ib.size() % R_B == 0) begin
        e.cyc = cyc + N_B + 2;
        e.vi  = round_conv(raw_sum(1, 0), ACC_B - OUT_B, OUT_B);
        e.vq  = round_conv(raw_sum(1, 1), ACC_B - OUT_B, OUT_B);
        exp_b.push_back(e);
      end
    end
    #1;
  endtask

  task automatic mon(input int d, input logic st, input longint vi, input longint vq);
    exp_t e;
    if (st) begin
      if (((d == 0) ? exp_a.size() : exp_b.size()) == 0) begin
        check_val($sformatf("spurious_strobe%0d", d), 1, 0);
      end else begin
        if (d == 0) e = exp_a.pop_front(); else e = exp_b.pop_front();
        check_val($sformatf("latency%0d", d), cyc, e.cyc);
        check_val($sformatf("data_i%0d", d), vi, e.vi);
        check_val($sformatf("data_q%0d", d), vq, e.vq);
        last_i[d] = e.vi;
        last_q[d] = e.vq;
      end
      seen_i[d]   = vi;
      seen_q[d]   = vq;
      prev_cyc[d] = last_cyc[d];
      last_cyc[d] = cyc;
      if (d == 1) begin
        outs_ib.push_back(vi);
        outs_qb.push_back(vq);
      end
    end else begin
      check_val($sformatf("hold_i%0d", d), vi, last_i[d]);
      check_val($sformatf("hold_q%0d", d), vq, last_q[d]);
    end
  endtask

  always @(negedge clock) begin
    mon(0, os_a, oi_a, oq_a);
    mon(1, os_b, oi_b, oq_b);
  end

  task automatic do_reset();
    reset = 1'b1;
    exp_a.delete(); exp_b.delete();
    hist_ia.delete(); hist_qa.delete(); hist_ib.delete(); hist_qb.delete();
    outs_ib.delete(); outs_qb.delete();
    for (int d = 0; d < 2; d++) begin
      last_i[d] = 0; last_q[d] = 0; seen_i[d] = 0; seen_q[d] = 0;
      last_cyc[d] = 0; prev_cyc[d] = 0;
    end
    #1;
    check_val("rst_strobe_a", os_a, 0);
    check_val("rst_i_a", oi_a, 0);
    check_val("rst_q_a", oq_a, 0);
    check_val("rst_strobe_b", os_b, 0);
    check_val("rst_i_b", oi_b, 0);
    check_val("rst_q_b", oq_b, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    build_h(0);
    build_h(1);
    #2;
    do_reset();

    // DC settle, continuous strobes
    for (int k = 0; k < R_A * 12; k++) drive(1, 1000, -1000, 0, 0, 0);
    idle(12);
    check_val("dc_i", seen_i[0], 3052);
    check_val("dc_q", seen_q[0], -3052);
    check_val("dc_period", last_cyc[0] - prev_cyc[0], R_A);

    // Reset with count at 17 and live integrators
    for (int k = 0; k < 97; k++) drive(1, rnd_s(), rnd_s(), 0, 0, 0);
    do_reset();

    // Full-scale DC; integrators wrap many times over this run
    for (int k = 0; k < 12000; k++) drive(1, 2097151, -2097152, 0, 0, 0);
    idle(12);
    check_val("fs_i", seen_i[0], 6399997);
    check_val("fs_q", seen_q[0], -6400000);
    check_val("fs_period", last_cyc[0] - prev_cyc[0], R_A);
    do_reset();

    // Gapped strobes, one in three
    for (int k = 0; k < R_A * 8 * 3; k++) drive((k % 3) == 0, 1000, -1000, 0, 0, 0);
    idle(12);
    check_val("gap_i", seen_i[0], 3052);
    check_val("gap_q", seen_q[0], -3052);
    check_val("gap_period", last_cyc[0] - prev_cyc[0], R_A * 3);
    do_reset();

    // Random data with random strobe gaps on both instances
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 9) < 7, rnd_s(), rnd_s(),
            $urandom_range(0, 9) < 6, rnd_s(), rnd_s());
    idle(12);
    do_reset();

    // Impulse into the small instance: raw responses 3,1,0,0 round to 1,0,0,0
    drive(0, 0, 0, 1, 1, 0);
    for (int k = 1; k < R_B * 5; k++) drive(0, 0, 0, 1, 0, 0);
    idle(10);
    if (outs_ib.size() < 4) begin
      check_val("imp_count", outs_ib.size(), 4);
    end else begin
      check_val("imp_i0", outs_ib[0], 1);
      check_val("imp_i1", outs_ib[1], 0);
      check_val("imp_i2", outs_ib[2], 0);
      check_val("imp_i3", outs_ib[3], 0);
      check_val("imp_q0", outs_qb[0], 0);
      check_val("imp_q1", outs_qb[1], 0);
    end

    check_val("drain_a", exp_a.size(), 0);
    check_val("drain_b", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
